// File: rtl/min_max_scheduler.sv
// rtl/min_max_scheduler.sv - two-port round-robin sequencer for the shared min/max engine
module min_max_scheduler #(
   parameter int N_ELEM = 16,
   parameter int AW     = 4,
   parameter int DW     = 8,
   parameter int TMO    = 255
) (
   input  logic          Clk,
   input  logic          Resetb,
   input  logic          Req0,
   input  logic          Req1,
   input  logic [DW-1:0] Din0,
   input  logic [DW-1:0] Din1,
   input  logic          Dvld0,
   input  logic          Dvld1,
   input  logic          Ack0,
   input  logic          Ack1,
   output logic          Gnt0,
   output logic          Gnt1,
   output logic          Rvld0,
   output logic          Rvld1,
   output logic [DW-1:0] Res_Max,
   output logic [DW-1:0] Res_Min,
   output logic          Res_Err,
   output logic          Wr_En,
   output logic [AW-1:0] Wr_Addr,
   output logic [DW-1:0] Wr_Data,
   output logic          Eng_Start,
   input  logic          Eng_Done,
   input  logic [DW-1:0] Eng_Max,
   input  logic [DW-1:0] Eng_Min,
   output logic          Busy
);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_LOAD   = 5'b00010,
      S_START  = 5'b00100,
      S_WAIT   = 5'b01000,
      S_RESULT = 5'b10000
   } state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic          last;
   logic          sel;
   logic [7:0]    tmr;
   logic [DW-1:0] res_max;
   logic [DW-1:0] res_min;
   logic          res_err;

   // Signals of whichever requester currently owns the engine
   logic          req_sel;
   logic          dvld_sel;
   logic          ack_sel;
   logic [DW-1:0] din_sel;
   logic          in_load;

   assign req_sel  = sel ? Req1  : Req0;
   assign dvld_sel = sel ? Dvld1 : Dvld0;
   assign ack_sel  = sel ? Ack1  : Ack0;
   assign din_sel  = sel ? Din1  : Din0;
   assign in_load  = (state == S_LOAD);

   // Array write port follows the granted stream directly so no beat is delayed
   assign Wr_En   = in_load & dvld_sel;
   assign Wr_Addr = cnt;
   assign Wr_Data = in_load ? din_sel : '0;

   // Remaining outputs are pure decodes of registered state
   assign Busy      = (state != S_IDLE);
   assign Gnt0      = Busy & ~sel;
   assign Gnt1      = Busy & sel;
   assign Eng_Start = (state == S_START);
   assign Rvld0     = (state == S_RESULT) & ~sel;
   assign Rvld1     = (state == S_RESULT) & sel;
   assign Res_Max   = res_max;
   assign Res_Min   = res_min;
   assign Res_Err   = res_err;

   // Job sequencing: arbitrate, load, kick engine, wait with watchdog, hand back result
   always_ff @(posedge Clk) begin
      if (!Resetb) begin
         state   <= S_IDLE;
         cnt     <= '0;
         tmr     <= '0;
         last    <= 1'b1;
         sel     <= 1'b0;
         res_max <= '0;
         res_min <= '0;
         res_err <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (Req0 | Req1) begin
                  // On a tie the requester not served last wins
                  sel   <= (Req0 & Req1) ? ~last : Req1;
                  cnt   <= '0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (!req_sel) begin
                  // Requester withdrew: abandon job without touching fairness state
                  cnt   <= '0;
                  state <= S_IDLE;
               end else if (dvld_sel) begin
                  cnt <= cnt + AW'(1);
                  if (cnt == AW'(N_ELEM - 1)) begin
                     state <= S_START;
                  end
               end
            end
            S_START: begin
               tmr   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (Eng_Done) begin
                  res_max <= Eng_Max;
                  res_min <= Eng_Min;
                  res_err <= 1'b0;
                  state   <= S_RESULT;
               end else if (tmr == 8'(TMO)) begin
                  res_max <= '0;
                  res_min <= '0;
                  res_err <= 1'b1;
                  state   <= S_RESULT;
               end else begin
                  tmr <= tmr + 8'd1;
               end
            end
            S_RESULT: begin
               if (ack_sel) begin
                  last  <= sel;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_min_max_scheduler.sv
// tb/tb_min_max_scheduler.sv - self-checking bench for min_max_scheduler
module tb_min_max_scheduler;

   localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_WAIT = 3, P_RESULT = 4;

   logic       Clk, Resetb;
   logic       Req0, Req1, Dvld0, Dvld1, Ack0, Ack1;
   logic [7:0] Din0, Din1;
   logic       Gnt0, Gnt1, Rvld0, Rvld1, Res_Err, Wr_En, Eng_Start, Eng_Done, Busy;
   logic [7:0] Res_Max, Res_Min, Wr_Data, Eng_Max, Eng_Min;
   logic [3:0] Wr_Addr;

   min_max_scheduler dut (
      .Clk(Clk), .Resetb(Resetb), .Req0(Req0), .Req1(Req1),
      .Din0(Din0), .Din1(Din1), .Dvld0(Dvld0), .Dvld1(Dvld1),
      .Ack0(Ack0), .Ack1(Ack1), .Gnt0(Gnt0), .Gnt1(Gnt1),
      .Rvld0(Rvld0), .Rvld1(Rvld1), .Res_Max(Res_Max), .Res_Min(Res_Min),
      .Res_Err(Res_Err), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
      .Eng_Start(Eng_Start), .Eng_Done(Eng_Done), .Eng_Max(Eng_Max),
      .Eng_Min(Eng_Min), .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] arr_max(input logic [7:0] a [16]);
      logic [7:0] r = 8'd0;
      for (int i = 0; i < 16; i++) if (a[i] > r) r = a[i];
      return r;
   endfunction

   function automatic logic [7:0] arr_min(input logic [7:0] a [16]);
      logic [7:0] r = 8'd255;
      for (int i = 0; i < 16; i++) if (a[i] < r) r = a[i];
      return r;
   endfunction

   // Engine stand-in: array filled by the write port, done after a programmable delay
   logic [7:0] mem [16];
   int         eng_cnt = 0;
   int         eng_lat = 3;
   bit         eng_en  = 1'b1;

   always @(posedge Clk) begin
      if (!Resetb) eng_cnt <= 0;
      else if (Eng_Start) eng_cnt <= eng_lat;
      else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
      if (Wr_En) mem[Wr_Addr] <= Wr_Data;
   end

   assign Eng_Done = eng_en && (eng_cnt == 1);
   assign Eng_Max  = arr_max(mem);
   assign Eng_Min  = arr_min(mem);

   // Job-level reference: phase, owner, beats accepted, wait time, expected result
   int         m_ph = P_IDLE;
   bit         m_who = 1'b0;
   bit         m_last = 1'b1;
   int         m_beats = 0;
   int         m_wait = 0;
   logic [7:0] m_dat [16];
   logic [7:0] m_max = 8'd0, m_min = 8'd0;
   bit         m_err = 1'b0;

   wire       mw_req  = m_who ? Req1  : Req0;
   wire       mw_dvld = m_who ? Dvld1 : Dvld0;
   wire       mw_ack  = m_who ? Ack1  : Ack0;
   wire [7:0] mw_din  = m_who ? Din1  : Din0;

   always @(posedge Clk) begin
      if (!Resetb) begin
         m_ph <= P_IDLE; m_last <= 1'b1; m_who <= 1'b0; m_beats <= 0; m_wait <= 0;
         m_max <= 8'd0; m_min <= 8'd0; m_err <= 1'b0;
      end else begin
         case (m_ph)
            P_IDLE: if (Req0 || Req1) begin
               m_who <= (Req0 && Req1) ? !m_last : Req1;
               m_beats <= 0;
               m_ph <= P_LOAD;
            end
            P_LOAD: if (!mw_req) begin
               m_ph <= P_IDLE;
               m_beats <= 0;
            end else if (mw_dvld) begin
               m_dat[m_beats] <= mw_din;
               m_beats <= m_beats + 1;
               if (m_beats == 15) m_ph <= P_START;
            end
            P_START: begin
               m_wait <= 0;
               m_ph <= P_WAIT;
            end
            P_WAIT: if (Eng_Done) begin
               m_max <= arr_max(m_dat); m_min <= arr_min(m_dat); m_err <= 1'b0;
               m_ph <= P_RESULT;
            end else if (m_wait == 255) begin
               m_max <= 8'd0; m_min <= 8'd0; m_err <= 1'b1;
               m_ph <= P_RESULT;
            end else begin
               m_wait <= m_wait + 1;
            end
            P_RESULT: if (mw_ack) begin
               m_last <= m_who;
               m_ph <= P_IDLE;
            end
            default: m_ph <= P_IDLE;
         endcase
      end
   end

   // Per-cycle comparison against the reference plus event bookkeeping
   bit cmp_on = 1'b0;
   int cyc = 0, start_cnt = 0, wr_cnt = 0, rvld1_cnt = 0, t_start = 0, t_rvld = 0;
   bit prev_rv = 1'b0;

   always @(negedge Clk) begin
      cyc <= cyc + 1;
      if (Eng_Start) begin start_cnt <= start_cnt + 1; t_start <= cyc; end
      if (Wr_En) wr_cnt <= wr_cnt + 1;
      if (Rvld1) rvld1_cnt <= rvld1_cnt + 1;
      if ((Rvld0 | Rvld1) && !prev_rv) t_rvld <= cyc;
      prev_rv <= Rvld0 | Rvld1;
      if (cmp_on) begin
         check("busy", Busy, m_ph != P_IDLE);
         check("gnt0", Gnt0, (m_ph != P_IDLE) && !m_who);
         check("gnt1", Gnt1, (m_ph != P_IDLE) && m_who);
         check("gnt_onehot", Gnt0 & Gnt1, 0);
         check("eng_start", Eng_Start, m_ph == P_START);
         check("rvld0", Rvld0, (m_ph == P_RESULT) && !m_who);
         check("rvld1", Rvld1, (m_ph == P_RESULT) && m_who);
         check("res_max", Res_Max, m_max);
         check("res_min", Res_Min, m_min);
         check("res_err", Res_Err, m_err);
         check("wr_en", Wr_En, (m_ph == P_LOAD) && mw_dvld);
         if ((m_ph == P_LOAD) && mw_dvld) begin
            check("wr_addr", Wr_Addr, m_beats);
            check("wr_data", Wr_Data, mw_din);
         end
      end
   end

   logic [7:0] dat [16];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input bit id, input bit dv, input logic [7:0] d);
      if (id) begin Dvld1 = dv; Din1 = d; end
      else    begin Dvld0 = dv; Din0 = d; end
   endtask

   task automatic set_ack(input bit id, input bit v);
      if (id) Ack1 = v; else Ack0 = v;
   endtask

   task automatic wait_gnt(output int id);
      int k = 0;
      while (!(Gnt0 | Gnt1) && k < 40) begin step(); k++; end
      check("gnt_wait", Gnt0 | Gnt1, 1);
      id = Gnt1 ? 1 : 0;
   endtask

   task automatic load(input int id, input bit gap, input bit foreign);
      int b = 0;
      int k = 0;
      bit dv;
      while (b < 16 && k < 100) begin
         dv = !(gap && k[0]);
         drive(id[0], dv, dat[b]);
         if (foreign) begin drive(!id[0], 1'b1, 8'hEE); set_ack(!id[0], k[0]); end
         step();
         if (dv) b++;
         k++;
      end
      drive(1'b0, 1'b0, 8'd0);
      drive(1'b1, 1'b0, 8'd0);
      set_ack(!id[0], 1'b0);
      check("load_beats", b, 16);
   endtask

   task automatic finish(input int id, input bit foreign,
                         output logic [7:0] rmax, output logic [7:0] rmin, output logic rerr);
      int k = 0;
      while (!(id[0] ? Rvld1 : Rvld0) && k < 600) begin step(); k++; end
      check("rvld_wait", id[0] ? Rvld1 : Rvld0, 1);
      if (foreign) begin set_ack(!id[0], 1'b1); step(); set_ack(!id[0], 1'b0); end
      rmax = Res_Max; rmin = Res_Min; rerr = Res_Err;
      set_ack(id[0], 1'b1);
      step();
      set_ack(id[0], 1'b0);
   endtask

   initial begin
      int id, s0, w0, r0;
      logic [7:0] rmax, rmin;
      logic rerr;
      Resetb = 1'b0; Req0 = 0; Req1 = 0; Dvld0 = 0; Dvld1 = 0; Ack0 = 0; Ack1 = 0;
      Din0 = 8'd0; Din1 = 8'd0;
      step(); step();
      cmp_on = 1'b1;
      check("rst_gnt0", Gnt0, 0); check("rst_gnt1", Gnt1, 0); check("rst_busy", Busy, 0);
      check("rst_rvld0", Rvld0, 0); check("rst_start", Eng_Start, 0);
      check("rst_max", Res_Max, 0); check("rst_err", Res_Err, 0);
      Resetb = 1'b1;

      // Single job, no gaps
      dat[0] = 8'd3; dat[1] = 8'd200;
      for (int i = 2; i < 15; i++) dat[i] = 8'(i + 5);
      dat[15] = 8'd15;
      Req0 = 1; s0 = start_cnt;
      wait_gnt(id); check("t1_id", id, 0);
      load(0, 0, 0);
      finish(0, 0, rmax, rmin, rerr);
      Req0 = 0;
      check("t1_gnt_drop", Gnt0, 0);
      check("t1_max", rmax, 200); check("t1_min", rmin, 3); check("t1_err", rerr, 0);
      check("t1_starts", start_cnt - s0, 1);

      // Tie with both held: 0, 1, 0 after reset
      Resetb = 0; step(); Resetb = 1;
      for (int i = 0; i < 16; i++) dat[i] = 8'(i * 37 + 11);
      Req0 = 1; Req1 = 1;
      for (int j = 0; j < 3; j++) begin
         wait_gnt(id); check("t2_order", id, (j == 1) ? 1 : 0);
         load(id, 0, 0);
         finish(id, 0, rmax, rmin, rerr);
      end
      Req0 = 0; Req1 = 0;
      step();

      // Gapped load with foreign Dvld1/Ack1
      for (int i = 0; i < 16; i++) dat[i] = 8'(i * 10 + 5);
      w0 = wr_cnt; r0 = rvld1_cnt;
      Req0 = 1;
      wait_gnt(id); check("t3_id", id, 0);
      load(0, 1, 1);
      finish(0, 1, rmax, rmin, rerr);
      Req0 = 0;
      check("t3_writes", wr_cnt - w0, 16); check("t3_rvld1", rvld1_cnt - r0, 0);
      check("t3_max", rmax, 155); check("t3_min", rmin, 5);

      // Abort by requester 1 after 5 beats; Last must still point at 0
      Req1 = 1;
      wait_gnt(id); check("t4_id", id, 1);
      s0 = start_cnt;
      for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b1, dat[i]); step(); end
      drive(1'b1, 1'b0, 8'd0); Req1 = 0;
      step();
      check("t4_idle", Busy, 0); check("t4_no_start", start_cnt - s0, 0);
      Req0 = 1; Req1 = 1;
      wait_gnt(id); check("t4_last_kept", id, 1);
      load(id, 0, 0);
      finish(id, 0, rmax, rmin, rerr);
      Req0 = 0; Req1 = 0;
      step();

      // Watchdog expiry, then Done on the expiry cycle
      eng_en = 0; Req0 = 1;
      wait_gnt(id); load(0, 0, 0);
      finish(0, 0, rmax, rmin, rerr);
      Req0 = 0;
      check("t5_err", rerr, 1); check("t5_max", rmax, 0); check("t5_min", rmin, 0);
      check("t5_lat", t_rvld - t_start, 257);
      step();
      eng_en = 1; eng_lat = 256; Req0 = 1;
      wait_gnt(id); load(0, 0, 0);
      finish(0, 0, rmax, rmin, rerr);
      Req0 = 0;
      check("t5b_err", rerr, 0); check("t5b_max", rmax, 155); check("t5b_min", rmin, 5);
      check("t5b_lat", t_rvld - t_start, 257);
      step();

      // Reset in WAIT, then a tie must go to requester 0
      eng_en = 0; eng_lat = 3; Req0 = 1;
      wait_gnt(id); load(0, 0, 0);
      for (int i = 0; i < 10; i++) step();
      Req1 = 1; Resetb = 0;
      step();
      check("t6_gnt0", Gnt0, 0); check("t6_gnt1", Gnt1, 0); check("t6_busy", Busy, 0);
      check("t6_rvld0", Rvld0, 0); check("t6_err", Res_Err, 0); check("t6_start", Eng_Start, 0);
      check("t6_wren", Wr_En, 0); check("t6_max", Res_Max, 0); check("t6_min", Res_Min, 0);
      Resetb = 1; eng_en = 1;
      wait_gnt(id); check("t6_tie", id, 0);
      load(id, 0, 0);
      finish(id, 0, rmax, rmin, rerr);
      Req0 = 0; Req1 = 0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
